// File: rtl/map_frame_timer.sv
// Frame position generator for the sender map path: 4 x 1041 byte-slot raster, early payload FIFO reads.
// Optional macro MAP_MFAS_EN adds the 8-bit multiframe alignment count output o_mfas.
module map_frame_timer #(
  parameter int ROWS      = 4,
  parameter int COLS      = 1041,
  parameter int OH_COLS   = 16,
  parameter int PYLD_COLS = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_fifo_empty,
  output logic        o_pyld_rd_en,
  output logic [1:0]  o_row_cnt,
  output logic [10:0] o_col_cnt,
  output logic        o_running,
  output logic        o_sof,
  output logic        o_underflow,
  output logic [15:0] o_frame_cnt
`ifdef MAP_MFAS_EN
  ,
  output logic [7:0]  o_mfas
`endif
);

  localparam logic [1:0]  LAST_ROW  = 2'(ROWS - 1);
  localparam logic [10:0] LAST_COL  = 11'(COLS - 1);
  // Requests lead the payload columns by one cycle to cover the FIFO read latency.
  localparam logic [10:0] REQ_FIRST = 11'(OH_COLS - 1);
  localparam logic [10:0] REQ_LAST  = 11'(OH_COLS + PYLD_COLS - 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  row_reg, row_next;
  logic [10:0] col_reg, col_next;
  logic        running_reg, running_next;
  logic        sof_reg, sof_next;
  logic        underflow_reg, underflow_next;
  logic [15:0] frame_cnt_reg, frame_cnt_next;
  logic        req;
  logic        end_of_row;
  logic        end_of_frame;

`ifdef MAP_MFAS_EN
  logic [7:0]  mfas_reg, mfas_next;
`endif

  always_comb begin
    end_of_row     = (col_reg == LAST_COL);
    end_of_frame   = end_of_row && (row_reg == LAST_ROW);
    req            = (state_reg == RUN) && (col_reg >= REQ_FIRST) && (col_reg <= REQ_LAST);

    state_next     = state_reg;
    row_next       = row_reg;
    col_next       = col_reg;
    frame_cnt_next = frame_cnt_reg;
    underflow_next = underflow_reg | (req & i_fifo_empty);
`ifdef MAP_MFAS_EN
    mfas_next      = mfas_reg;
`endif

    case (state_reg)
      IDLE: begin
        row_next = 2'd0;
        col_next = 11'd0;
`ifdef MAP_MFAS_EN
        mfas_next = 8'd0;
`endif
        if (i_start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (end_of_row) begin
          col_next = 11'd0;
          if (end_of_frame) begin
            row_next       = 2'd0;
            frame_cnt_next = frame_cnt_reg + 16'd1;
`ifdef MAP_MFAS_EN
            mfas_next      = mfas_reg + 8'd1;
`endif
          end else begin
            row_next = row_reg + 2'd1;
          end
        end else begin
          col_next = col_reg + 11'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Flags are computed from the next position so they register in step with the counters.
    running_next = (state_next == RUN);
    sof_next     = (state_next == RUN) && (row_next == 2'd0) && (col_next == 11'd0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      row_reg       <= 2'd0;
      col_reg       <= 11'd0;
      running_reg   <= 1'b0;
      sof_reg       <= 1'b0;
      underflow_reg <= 1'b0;
      frame_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      running_reg   <= running_next;
      sof_reg       <= sof_next;
      underflow_reg <= underflow_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

`ifdef MAP_MFAS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mfas_reg <= 8'd0;
    end else begin
      mfas_reg <= mfas_next;
    end
  end

  assign o_mfas = mfas_reg;
`endif

  assign o_pyld_rd_en = req & ~i_fifo_empty;
  assign o_row_cnt    = row_reg;
  assign o_col_cnt    = col_reg;
  assign o_running    = running_reg;
  assign o_sof        = sof_reg;
  assign o_underflow  = underflow_reg;
  assign o_frame_cnt  = frame_cnt_reg;

endmodule
